uart_tx_arbiter: RTL and testbench

- Shares one `uart_tx` byte transmitter among `NUM_REQ` byte requesters on the `sys_clk` domain.
  - Arbitration is round-robin, with packet locking so a multi-byte message from one requester is never interleaved with another's.
  - It sequences the transmitter's start/busy handshake.
- It sits between the on-chip message sources (loopback echo path, status reporters, debug dump) and the single `uart_tx` instance driving `uart_txd`.

---
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locking arbiter sharing one uart_tx byte
//   transmitter among NUM_REQ byte requesters. Accept in T, tx_en in T+1; one
//   byte in flight, no buffering; requesters hold their byte until req_ready.
// Ports:
//   sys_clk/sys_rst            clock, synchronous active-high reset
//   req_valid/req_data/req_last per-requester byte offer (byte i at [8i+7:8i])
//   req_ready                  one-hot single-cycle accept pulse
//   tx_en/tx_data/tx_busy      start pulse, held byte and busy from uart_tx
//   grant_id/locked            last accepted requester, packet lock owned by it
//   start_err                  one-cycle pulse when tx_busy never rose after tx_en
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 4,
    localparam int IDW          = $clog2(NUM_REQ)
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_en,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 locked,
    output logic                 start_err
);

    localparam int CNT_W = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t           state, state_nxt;
    // Round-robin pointer is kept apart from grant_id because the two reset
    // to different values: the pointer starts at NUM_REQ-1 so requester 0
    // is scanned first, while grant_id reports 0 out of reset.
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   win_idx;
    logic [IDW-1:0]   scan_sel;
    logic             win_found;
    logic             accept;
    logic             timeout;
    logic [CNT_W-1:0] cnt;

    // Winner selection: the lock owner alone when locked, otherwise the
    // first valid requester after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_sel  = '0;
        if (locked) begin
            win_found = req_valid[grant_id];
            win_idx   = grant_id;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                scan_sel = IDW'((int'(ptr) + k) % NUM_REQ);
                if (!win_found && req_valid[scan_sel]) begin
                    win_found = 1'b1;
                    win_idx   = scan_sel;
                end
            end
        end
    end

    // Reset gating keeps requesters from seeing an accept that the state
    // registers are about to discard.
    assign accept  = (state == IDLE) && !tx_busy && win_found && !sys_rst;
    assign timeout = (state == WAIT_START) && !tx_busy && (cnt == TO_LAST);

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        tx_en     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SEND;
                    req_ready = NUM_REQ'(1) << win_idx;
                end
            end
            SEND: begin
                tx_en     = !sys_rst;
                state_nxt = WAIT_START;
            end
            WAIT_START: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            tx_data   <= 8'h00;
            grant_id  <= '0;
            locked    <= 1'b0;
            ptr       <= IDW'(NUM_REQ - 1);
            start_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            start_err <= timeout;
            if (accept) begin
                tx_data  <= req_data[8*win_idx +: 8];
                grant_id <= win_idx;
                ptr      <= win_idx;
                locked   <= ~req_last[win_idx];
            end
            if (state == SEND) begin
                cnt <= '0;
            end else if ((state == WAIT_START) && !tx_busy) begin
                cnt <= cnt + CNT_W'(1);
            end
            // A transmitter that never starts would otherwise pin the lock
            // on its owner forever; drop it but keep the pointer.
            if (timeout) begin
                locked <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench for uart_tx_arbiter with requester
//   queues, a uart_tx busy model and a transaction-level arbitration model.
// Ports: none (drives every DUT port, clock period 10 ns).
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } item_t;

    logic           sys_clk = 1'b0;
    logic           sys_rst;
    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [8*N-1:0] req_data;
    logic           tx_en, tx_busy, locked, start_err;
    logic [7:0]     tx_data;
    logic [1:0]     grant_id;

    always #5 sys_clk = ~sys_clk;

    uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(TO)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_en(tx_en), .tx_data(tx_data),
        .tx_busy(tx_busy), .grant_id(grant_id), .locked(locked),
        .start_err(start_err)
    );

    int n_checks = 0, n_pass = 0;
    int cyc = 0;

    // environment: requester queues, enables, uart_tx busy model
    item_t    rq[N][$];
    bit [N-1:0] en = '1;
    bit       rst_req = 1'b0;
    int       mode = 0;            // 0: busy follows tx_en, 1: busy stuck low, 2: busy forced high
    int       bs = -100, be = -100, cur_f = 3, fmin = 3, fmax = 3;
    bit       rand_mode = 1'b0;

    // reference model state
    bit         m_lock;
    logic [1:0] m_ptr, m_grant;
    logic [7:0] m_data;
    int         next_ok, la, err_cyc;
    bit         model_on = 1'b0;
    int         model_diff = 0;

    // expectations and samples for the current cycle
    logic [N-1:0] e_ready, s_ready;
    logic         e_txen, s_txen, e_lock, s_lock, e_err, s_err;
    logic [7:0]   e_txd, s_txd;
    logic [1:0]   e_grant, s_grant;

    // logs
    int         acc_id[$];
    logic [7:0] acc_dat[$];
    int         acc_cyc[$];
    logic [N-1:0] acc_rdy[$];
    logic       lk_log[$];
    int         err_log[$];
    logic [7:0] txd_log[$];
    bit         prev_acc = 1'b0;

    function automatic int predict(logic [N-1:0] v);
        logic [1:0] ix;
        if (m_lock) return v[m_grant] ? int'(m_grant) : -1;
        for (int k = 1; k <= N; k++) begin
            ix = 2'((int'(m_ptr) + k) % N);
            if (v[ix]) return int'(ix);
        end
        return -1;
    endfunction

    task automatic step();
        logic [N-1:0] v;
        int  win;
        bit  acc;
        bit  busy_now;
        @(posedge sys_clk);
        #1;
        cyc++;
        if (cyc == err_cyc) m_lock = 1'b0;
        busy_now = (mode == 2) || (mode == 0 && cyc >= bs && cyc <= be);
        tx_busy  = busy_now;
        sys_rst  = rst_req;
        v = '0; req_last = '0; req_data = '0;
        for (int i = 0; i < N; i++) begin
            if (en[i] && rq[i].size() > 0) begin
                v[i] = 1'b1;
                req_data[8*i +: 8] = rq[i][0].d;
                req_last[i] = rq[i][0].l;
            end
        end
        req_valid = v;
        e_txd   = m_data;
        e_grant = m_grant;
        e_lock  = m_lock;
        e_err   = (cyc == err_cyc);
        e_txen  = (cyc == la + 1) && !rst_req;
        win     = predict(v);
        acc     = !rst_req && cyc >= next_ok && !busy_now && win >= 0;
        e_ready = acc ? (N'(1) << win) : '0;
        @(negedge sys_clk);
        s_ready = req_ready; s_txen = tx_en; s_txd = tx_data;
        s_grant = grant_id;  s_lock = locked; s_err = start_err;
        if (model_on && {s_ready, s_txen, s_txd, s_grant, s_lock, s_err} !==
                        {e_ready, e_txen, e_txd, e_grant, e_lock, e_err})
            model_diff++;
        if (prev_acc) lk_log.push_back(s_lock);
        prev_acc = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (s_ready[i] && v[i]) begin
                acc_id.push_back(i);
                acc_dat.push_back(rq[i][0].d);
                acc_cyc.push_back(cyc);
                acc_rdy.push_back(s_ready);
                void'(rq[i].pop_front());
                prev_acc = 1'b1;
            end
        end
        if (s_txen) begin
            txd_log.push_back(s_txd);
            if (mode == 0) begin bs = cyc + 1; be = cyc + cur_f; end
        end
        if (s_err) err_log.push_back(cyc);
        if (rst_req) begin
            m_lock = 1'b0; m_ptr = 2'(N - 1); m_grant = '0; m_data = '0;
            next_ok = cyc + 1; la = -10; err_cyc = -10;
        end else if (acc) begin
            m_data  = req_data[8*win +: 8];
            m_grant = 2'(win);
            m_ptr   = 2'(win);
            m_lock  = !req_last[win];
            la      = cyc;
            if (rand_mode) mode = ($urandom_range(0, 9) < 2) ? 1 : 0;
            cur_f = $urandom_range(fmin, fmax);
            if (mode == 1) begin
                err_cyc = cyc + 2 + TO;
                next_ok = err_cyc;
            end else begin
                next_ok = cyc + 3 + cur_f;
            end
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) rq[i].delete();
        acc_id.delete(); acc_dat.delete(); acc_cyc.delete(); acc_rdy.delete();
        lk_log.delete(); err_log.delete(); txd_log.delete();
        en = '1; mode = 0; bs = -100; be = -100; rand_mode = 1'b0;
        model_on = 1'b0; model_diff = 0; prev_acc = 1'b0;
        rst_req = 1'b1;
        step();
        step();
        rst_req = 1'b0;
        model_on = 1'b1;
    endtask

    task automatic run_until(int n, int budget);
        for (int k = 0; k < budget && acc_id.size() < n; k++) step();
    endtask

    task automatic test_reset();
        do_reset();
        step();
        n_checks++; if (s_ready !== 4'b0000) $display("FAIL reset_ready got %b want 0000", s_ready); else n_pass++;
        n_checks++; if (s_txen !== 1'b0) $display("FAIL reset_tx_en got %b want 0", s_txen); else n_pass++;
        n_checks++; if (s_txd !== 8'h00) $display("FAIL reset_tx_data got %h want 00", s_txd); else n_pass++;
        n_checks++; if (s_grant !== 2'd0) $display("FAIL reset_grant got %0d want 0", s_grant); else n_pass++;
        n_checks++; if (s_lock !== 1'b0) $display("FAIL reset_locked got %b want 0", s_lock); else n_pass++;
        n_checks++; if (s_err !== 1'b0) $display("FAIL reset_start_err got %b want 0", s_err); else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        fmin = 3; fmax = 3;
        rq[0].push_back({8'h55, 1'b1});
        run_until(1, 30);
        n_checks++; if (acc_id.size() !== 1) $display("FAIL single_accept got %0d accepts want 1", acc_id.size()); else n_pass++;
        n_checks++; if (acc_rdy[0] !== 4'b0001) $display("FAIL single_ready got %b want 0001", acc_rdy[0]); else n_pass++;
        step();
        n_checks++; if ({s_ready, s_txen} !== 5'b0000_1) $display("FAIL single_txen got ready=%b tx_en=%b want 0000/1", s_ready, s_txen); else n_pass++;
        n_checks++; if (s_txd !== 8'h55) $display("FAIL single_tx_data got %h want 55", s_txd); else n_pass++;
        n_checks++; if ({s_grant, s_lock} !== 3'b00_0) $display("FAIL single_grant got grant=%0d locked=%b want 0/0", s_grant, s_lock); else n_pass++;
        repeat (10) step();
        n_checks++; if (model_diff !== 0) $display("FAIL single_model got %0d diff cycles want 0", model_diff); else n_pass++;
    endtask

    task automatic test_round_robin();
        int exp_id[5] = '{0, 1, 2, 3, 0};
        do_reset();
        fmin = 2; fmax = 4;
        for (int i = 0; i < N; i++)
            repeat (3) rq[i].push_back({8'hA0 + 8'(i), 1'b1});
        run_until(5, 200);
        step();
        n_checks++; if (txd_log.size() !== 5) $display("FAIL rr_txen_count got %0d want 5", txd_log.size()); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (acc_id[k] !== exp_id[k] || txd_log[k] !== 8'hA0 + 8'(exp_id[k]))
                $display("FAIL rr_order[%0d] got id=%0d data=%h want id=%0d data=%h", k, acc_id[k], txd_log[k], exp_id[k], 8'hA0 + 8'(exp_id[k]));
            else n_pass++;
        end
        n_checks++; if (model_diff !== 0) $display("FAIL rr_model got %0d diff cycles want 0", model_diff); else n_pass++;
    endtask

    task automatic test_packet_lock();
        int         exp_id[4]  = '{1, 1, 1, 2};
        logic [7:0] exp_d[4]   = '{8'h10, 8'h11, 8'h12, 8'h20};
        logic       exp_lk[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        fmin = 1; fmax = 5;
        rq[1].push_back({8'h10, 1'b0});
        rq[1].push_back({8'h11, 1'b0});
        rq[1].push_back({8'h12, 1'b1});
        rq[2].push_back({8'h20, 1'b1});
        run_until(4, 200);
        step();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (acc_id[k] !== exp_id[k] || acc_dat[k] !== exp_d[k] || lk_log[k] !== exp_lk[k])
                $display("FAIL lock_seq[%0d] got id=%0d data=%h locked=%b want id=%0d data=%h locked=%b",
                         k, acc_id[k], acc_dat[k], lk_log[k], exp_id[k], exp_d[k], exp_lk[k]);
            else n_pass++;
        end
        n_checks++; if (model_diff !== 0) $display("FAIL lock_model got %0d diff cycles want 0", model_diff); else n_pass++;
    endtask

    task automatic test_lock_hold();
        int         exp_id[3] = '{1, 1, 0};
        logic [7:0] exp_d[3]  = '{8'h30, 8'h31, 8'h40};
        do_reset();
        fmin = 3; fmax = 3;
        en = 4'b0010;
        rq[1].push_back({8'h30, 1'b0});
        rq[0].push_back({8'h40, 1'b1});
        run_until(1, 50);
        en = '1;
        repeat (200) step();
        n_checks++; if (acc_id.size() !== 1) $display("FAIL hold_window got %0d accepts want 1", acc_id.size()); else n_pass++;
        rq[1].push_back({8'h31, 1'b1});
        run_until(3, 100);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (acc_id[k] !== exp_id[k] || acc_dat[k] !== exp_d[k])
                $display("FAIL hold_seq[%0d] got id=%0d data=%h want id=%0d data=%h", k, acc_id[k], acc_dat[k], exp_id[k], exp_d[k]);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        int exp_id[3] = '{0, 1, 2};
        do_reset();
        mode = 1;
        rq[0].push_back({8'h50, 1'b0});
        rq[1].push_back({8'h51, 1'b1});
        rq[2].push_back({8'h52, 1'b1});
        run_until(3, 100);
        repeat (TO + 3) step();
        n_checks++; if (err_log.size() !== 3) $display("FAIL timeout_count got %0d want 3", err_log.size()); else n_pass++;
        n_checks++; if (lk_log[0] !== 1'b1) $display("FAIL timeout_lock_first got %b want 1", lk_log[0]); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (acc_id[k] !== exp_id[k] || err_log[k] - acc_cyc[k] !== 2 + TO)
                $display("FAIL timeout_seq[%0d] got id=%0d err_delay=%0d want id=%0d err_delay=%0d",
                         k, acc_id[k], err_log[k] - acc_cyc[k], exp_id[k], 2 + TO);
            else n_pass++;
        end
        n_checks++; if (model_diff !== 0) $display("FAIL timeout_model got %0d diff cycles want 0", model_diff); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int fall;
        do_reset();
        fmin = 30; fmax = 30;
        rq[0].push_back({8'h60, 1'b1});
        run_until(1, 20);
        repeat (5) step();
        mode = 2;
        rq[0].push_back({8'h62, 1'b1});
        rq[1].push_back({8'h61, 1'b1});
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        step();
        n_checks++;
        if ({s_ready, s_txen, s_txd, s_grant, s_lock, s_err} !== 17'h0)
            $display("FAIL midrst_outputs got ready=%b tx_en=%b data=%h grant=%0d locked=%b err=%b want all 0",
                     s_ready, s_txen, s_txd, s_grant, s_lock, s_err);
        else n_pass++;
        repeat (10) step();
        n_checks++; if (acc_id.size() !== 1) $display("FAIL midrst_busy_block got %0d accepts want 1", acc_id.size()); else n_pass++;
        mode = 0; bs = -100; be = -100;
        fmin = 3; fmax = 3;
        fall = cyc + 1;
        run_until(2, 20);
        n_checks++;
        if (acc_id[1] !== 0 || acc_dat[1] !== 8'h62 || acc_cyc[1] !== fall)
            $display("FAIL midrst_first got id=%0d data=%h cyc=%0d want id=0 data=62 cyc=%0d", acc_id[1], acc_dat[1], acc_cyc[1], fall);
        else n_pass++;
        n_checks++; if (model_diff !== 0) $display("FAIL midrst_model got %0d diff cycles want 0", model_diff); else n_pass++;
    endtask

    task automatic test_random();
        int total = 0;
        int len;
        do_reset();
        rand_mode = 1'b1;
        fmin = 1; fmax = 5;
        for (int i = 0; i < N; i++) begin
            repeat (12) begin
                len = $urandom_range(1, 3);
                for (int b = 0; b < len; b++) begin
                    rq[i].push_back({8'($urandom), b == len - 1});
                    total++;
                end
            end
        end
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 9) < 8);
            step();
            n_checks++;
            if ({s_ready, s_txen, s_txd, s_grant, s_lock, s_err} !== {e_ready, e_txen, e_txd, e_grant, e_lock, e_err})
                $display("FAIL random cyc=%0d got ready=%b en=%b data=%h grant=%0d lock=%b err=%b want ready=%b en=%b data=%h grant=%0d lock=%b err=%b",
                         cyc, s_ready, s_txen, s_txd, s_grant, s_lock, s_err, e_ready, e_txen, e_txd, e_grant, e_lock, e_err);
            else n_pass++;
        end
        n_checks++; if (acc_id.size() !== total) $display("FAIL random_drain got %0d accepts want %0d", acc_id.size(), total); else n_pass++;
        rand_mode = 1'b0;
        mode = 0;
    endtask

    initial begin
        sys_rst = 1'b1; tx_busy = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_packet_lock();
        test_lock_hold();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
